// File: rtl/mips32_fetch_queue.sv
// Instruction-fetch stage: issues word reads to instruction memory, buffers returned
// words with their NPC in a small FIFO and hands them to decode over valid/ready.
module mips32_fetch_queue #(
    parameter int          AW     = 10,
    parameter int          DEPTH  = 4,
    parameter logic [5:0]  HLT_OP = 6'h3f
) (
    input  logic                       clk1,
    input  logic                       rst,
    output logic                       imem_rd,
    output logic [AW-1:0]              imem_addr,
    input  logic [31:0]                imem_data,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [31:0]                id_ir,
    output logic [31:0]                id_npc,
    output logic                       halted_fetch,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [31:0]   pc;
    logic [31:0]   tag;
    logic          inflight;
    logic          halted;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [31:0]   fifo_ir  [DEPTH];
    logic [31:0]   fifo_npc [DEPTH];

    logic [CW:0]   credit_used;
    logic          issue;
    logic          push;
    logic          pop;
    logic          push_is_hlt;

    // Handshake: a word moves to ID in any cycle where id_valid && id_ready are
    // both high; id_ir/id_npc stay stable while id_valid is high and id_ready low.

    // Outstanding credit counts both buffered words and the one fetch in flight,
    // so a response always finds a free slot.
    assign credit_used = (CW+1)'(count) + (CW+1)'(inflight);
    assign issue       = !rst && !halted && !redirect && (credit_used < (CW+1)'(DEPTH));
    assign push        = inflight && !halted && !redirect;
    assign pop         = id_valid && id_ready;
    assign push_is_hlt = (imem_data[31:26] == HLT_OP);

    assign imem_rd      = issue;
    assign imem_addr    = pc[AW-1:0];
    assign id_valid     = (count != '0) && !redirect;
    assign id_ir        = fifo_ir[rd_ptr];
    assign id_npc       = fifo_npc[rd_ptr];
    assign halted_fetch = halted;
    assign occupancy    = count;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            pc       <= '0;
            tag      <= '0;
            inflight <= 1'b0;
            halted   <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_ir[i]  <= '0;
                fifo_npc[i] <= '0;
            end
        end else if (redirect) begin
            pc       <= redirect_pc;
            inflight <= 1'b0;
            halted   <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc  <= pc + 32'd1;
                tag <= pc;
            end
            if (push) begin
                fifo_ir[wr_ptr]  <= imem_data;
                fifo_npc[wr_ptr] <= tag + 32'd1;
                wr_ptr           <= wr_ptr + PW'(1);
                if (push_is_hlt) begin
                    halted <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Self-checking bench for mips32_fetch_queue: directed scenarios followed by random
// redirect/ready/reset traffic, all compared against a queue-based fetch model.
module tb_mips32_fetch_queue;

    localparam int AW    = 10;
    localparam int DEPTH = 4;

    logic          clk1 = 1'b0;
    logic          rst  = 1'b1;
    logic          imem_rd;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_data = '0;
    logic          redirect = 1'b0;
    logic [31:0]   redirect_pc = '0;
    logic          id_valid;
    logic          id_ready = 1'b0;
    logic [31:0]   id_ir;
    logic [31:0]   id_npc;
    logic          halted_fetch;
    logic [2:0]    occupancy;

    mips32_fetch_queue #(.AW(AW), .DEPTH(DEPTH), .HLT_OP(6'h3f)) dut (
        .clk1(clk1), .rst(rst), .imem_rd(imem_rd), .imem_addr(imem_addr),
        .imem_data(imem_data), .redirect(redirect), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_ir(id_ir), .id_npc(id_npc),
        .halted_fetch(halted_fetch), .occupancy(occupancy)
    );

    // clock / reset
    always #5 clk1 = ~clk1;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] mem [1024];

    // reference model: program counter, one pending fetch, queue of delivered words
    logic [31:0] m_pc;
    logic [31:0] m_tag;
    logic        m_infl;
    logic        m_halt;
    logic [31:0] exp_q[$];
    logic [31:0] exp_npc_q[$];

    // last values seen at the falling edge
    logic        obs_rd, obs_valid, obs_halt;
    logic [31:0] obs_addr, obs_occ;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] non_hlt(input logic [31:0] w);
        return (w[31:26] == 6'h3f) ? (w ^ 32'h0400_0000) : w;
    endfunction

    function automatic void model_clear();
        m_pc   = '0;
        m_tag  = '0;
        m_infl = 1'b0;
        m_halt = 1'b0;
        exp_q.delete();
        exp_npc_q.delete();
    endfunction

    // one pipeline cycle: called at posedge+1, returns at the next posedge+1
    task automatic cyc(input logic rdr, input logic [31:0] rpc, input logic rdy);
        logic        e_rd, e_valid, do_pop, do_push;
        logic [31:0] word;
        logic        rd_s;
        logic [AW-1:0] addr_s;
        redirect    = rdr;
        redirect_pc = rpc;
        id_ready    = rdy;
        @(negedge clk1);
        e_rd    = !m_halt && !rdr && ((exp_q.size() + int'(m_infl)) < DEPTH);
        e_valid = (exp_q.size() != 0) && !rdr;
        check_eq("imem_rd", 32'(imem_rd), 32'(e_rd));
        check_eq("imem_addr", 32'(imem_addr), 32'(m_pc[AW-1:0]));
        check_eq("id_valid", 32'(id_valid), 32'(e_valid));
        check_eq("occupancy", 32'(occupancy), 32'(exp_q.size()));
        check_eq("halted_fetch", 32'(halted_fetch), 32'(m_halt));
        if (e_valid) begin
            check_eq("id_ir", id_ir, exp_q[0]);
            check_eq("id_npc", id_npc, exp_npc_q[0]);
        end
        obs_rd    = imem_rd;
        obs_valid = id_valid;
        obs_halt  = halted_fetch;
        obs_addr  = 32'(imem_addr);
        obs_occ   = 32'(occupancy);
        rd_s      = imem_rd;
        addr_s    = imem_addr;
        @(posedge clk1);
        if (rdr) begin
            exp_q.delete();
            exp_npc_q.delete();
            m_pc   = rpc;
            m_halt = 1'b0;
            m_infl = 1'b0;
        end else begin
            do_pop  = (exp_q.size() != 0) && rdy;
            do_push = m_infl && !m_halt;
            word    = mem[m_tag[AW-1:0]];
            if (do_pop) begin
                void'(exp_q.pop_front());
                void'(exp_npc_q.pop_front());
            end
            if (do_push) begin
                exp_q.push_back(word);
                exp_npc_q.push_back(m_tag + 32'd1);
                if (word[31:26] == 6'h3f) m_halt = 1'b1;
            end
            if (e_rd) begin
                m_tag = m_pc;
                m_pc  = m_pc + 32'd1;
            end
            m_infl = e_rd;
        end
        #1;
        imem_data = rd_s ? mem[addr_s] : $urandom;
    endtask

    // reset pulse starting between clock edges; called at posedge+1
    task automatic do_reset();
        rst = 1'b1;
        redirect = 1'b0;
        id_ready = 1'b0;
        #2;
        check_eq("rst_imem_rd", 32'(imem_rd), 32'd0);
        check_eq("rst_id_valid", 32'(id_valid), 32'd0);
        check_eq("rst_occupancy", 32'(occupancy), 32'd0);
        check_eq("rst_halted", 32'(halted_fetch), 32'd0);
        check_eq("rst_imem_addr", 32'(imem_addr), 32'd0);
        check_eq("rst_id_ir", id_ir, 32'd0);
        check_eq("rst_id_npc", id_npc, 32'd0);
        model_clear();
        imem_data = '0;
        @(posedge clk1);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] rpc;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = non_hlt($urandom);
            if (i >= 16 && $urandom_range(0, 40) == 0) mem[i] = 32'hfc00_0000;
        end
        mem[0] = 32'h2801_000a;
        mem[1] = 32'h2802_0014;
        mem[2] = 32'h2803_0019;
        mem[5] = 32'h0022_2000;
        mem[8] = 32'hfc00_0000;
        model_clear();
        @(posedge clk1);
        #1;

        // 1: back-to-back delivery, first id_valid two cycles after first fetch
        do_reset();
        cyc(1'b0, '0, 1'b1);
        check_eq("t1_first_rd", 32'(obs_rd), 32'd1);
        cyc(1'b0, '0, 1'b1);
        check_eq("t1_c1_valid", 32'(obs_valid), 32'd0);
        cyc(1'b0, '0, 1'b1);
        check_eq("t1_c2_valid", 32'(obs_valid), 32'd1);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1);

        // 2: backpressure from reset fills the FIFO and stalls fetch
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b0);
        check_eq("t2_occ_full", obs_occ, 32'd4);
        check_eq("t2_addr", obs_addr, 32'd4);
        check_eq("t2_rd_stall", 32'(obs_rd), 32'd0);
        for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1);

        // 3: HLT at word 8 stops fetch permanently
        cyc(1'b1, 32'd6, 1'b1);
        for (int i = 0; i < 10; i++) cyc(1'b0, '0, 1'b1);
        check_eq("t3_halted", 32'(obs_halt), 32'd1);
        check_eq("t3_rd", 32'(obs_rd), 32'd0);
        check_eq("t3_occ", obs_occ, 32'd0);

        // 4: flush with 3 queued and 1 in flight
        cyc(1'b1, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b0);
        cyc(1'b1, 32'd5, 1'b0);
        check_eq("t4_occ_before", obs_occ, 32'd3);
        cyc(1'b0, '0, 1'b1);
        check_eq("t4_occ_after", obs_occ, 32'd0);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1);

        // 5: redirect coinciding with the HLT response
        cyc(1'b1, 32'd8, 1'b1);
        cyc(1'b0, '0, 1'b1);
        cyc(1'b1, 32'd20, 1'b1);
        cyc(1'b0, '0, 1'b1);
        check_eq("t5_halted", 32'(obs_halt), 32'd0);
        check_eq("t5_addr", obs_addr, 32'd20);
        check_eq("t5_rd", 32'(obs_rd), 32'd1);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1);

        // 6: reset mid-stream
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0);
        do_reset();
        cyc(1'b0, '0, 1'b1);
        check_eq("t6_addr", obs_addr, 32'd0);
        for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1);

        // PC wrap-around at the top of the 32-bit space
        cyc(1'b1, 32'hffff_fffe, 1'b1);
        for (int i = 0; i < 6; i++) cyc(1'b0, '0, 1'b1);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                rpc = ($urandom_range(0, 7) == 0) ? (32'hffff_fffc + 32'($urandom_range(0, 3)))
                                                  : 32'($urandom_range(0, 1023));
                cyc($urandom_range(0, 19) == 0, rpc, $urandom_range(0, 3) != 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
